// File: rtl/issue_pkg.sv
// Shared types for the issue-queue slot: slot state encoding, stored uop layout
// and the branch-mask pruning helper.
package issue_pkg;

    localparam int unsigned ISSUE_PREG_W    = 7;
    localparam int unsigned ISSUE_BR_MASK_W = 12;
    localparam int unsigned ISSUE_PAYLOAD_W = 64;

    typedef enum logic [1:0] {
        S_INVALID = 2'd0,
        S_VALID_1 = 2'd1,
        S_VALID_2 = 2'd2
    } slot_state_e;

    // Everything the slot keeps besides its state; the payload is opaque.
    typedef struct packed {
        logic [ISSUE_PAYLOAD_W-1:0] payload;
        logic [ISSUE_PREG_W-1:0]    pdst;
        logic [ISSUE_PREG_W-1:0]    prs1;
        logic [ISSUE_PREG_W-1:0]    prs2;
        logic                       prs1_busy;
        logic                       prs2_busy;
        logic [ISSUE_BR_MASK_W-1:0] br_mask;
    } slot_uop_t;

    // Drop a correctly-predicted branch from a dependency mask.
    function automatic logic [ISSUE_BR_MASK_W-1:0] prune_mask(
        input logic [ISSUE_BR_MASK_W-1:0] mask,
        input logic [ISSUE_BR_MASK_W-1:0] resolved,
        input logic                       en
    );
        return en ? (mask & ~resolved) : mask;
    endfunction

endpackage

// File: rtl/wakeup_match.sv
// Compares one source tag against every wakeup port and reports any hit.
module wakeup_match #(
    parameter int unsigned NUM_WAKEUP = 2,
    parameter int unsigned PREG_W     = 7
) (
    input  logic [PREG_W-1:0]            tag_i,
    input  logic [NUM_WAKEUP-1:0]        wakeup_valid_i,
    input  logic [NUM_WAKEUP*PREG_W-1:0] wakeup_pdst_i,
    output logic                         hit_o
);

    // OR-reduce over ports; several ports hitting the same tag is harmless.
    always_comb begin
        hit_o = 1'b0;
        for (int i = 0; i < NUM_WAKEUP; i++) begin
            if (wakeup_valid_i[i] && (wakeup_pdst_i[i*PREG_W +: PREG_W] == tag_i)) begin
                hit_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/issue_slot_gen.sv
// One collapsing issue-queue slot: holds a uop, tracks source readiness, prunes
// or kills on branch resolution and requests issue (twice for two-part stores).
// Optional build macro ISSUE_SLOT_WAKEUP_BYPASS_EN folds same-cycle wakeups into
// the request so a woken uop can be granted in the wakeup cycle.
// Stored fields are sized by issue_pkg; the width parameters must match it.
module issue_slot_gen
    import issue_pkg::*;
#(
    parameter int unsigned NUM_WAKEUP = 2,
    parameter int unsigned PREG_W     = ISSUE_PREG_W,
    parameter int unsigned BR_MASK_W  = ISSUE_BR_MASK_W,
    parameter int unsigned PAYLOAD_W  = ISSUE_PAYLOAD_W
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    input  logic                         in_two_part,
    input  logic [PAYLOAD_W-1:0]         in_payload,
    input  logic [PREG_W-1:0]            in_pdst,
    input  logic [PREG_W-1:0]            in_prs1,
    input  logic [PREG_W-1:0]            in_prs2,
    input  logic                         in_prs1_busy,
    input  logic                         in_prs2_busy,
    input  logic [BR_MASK_W-1:0]         in_br_mask,
    input  logic [NUM_WAKEUP-1:0]        wakeup_valid,
    input  logic [NUM_WAKEUP*PREG_W-1:0] wakeup_pdst,
    input  logic                         br_resolve_valid,
    input  logic [BR_MASK_W-1:0]         br_resolve_mask,
    input  logic                         br_mispredict,
    input  logic                         grant,
    input  logic                         kill,
    input  logic                         clear,
    output logic                         valid,
    output logic                         will_be_valid,
    output logic                         request,
    output logic                         out_valid,
    output logic                         out_two_part,
    output logic [PAYLOAD_W-1:0]         out_payload,
    output logic [PREG_W-1:0]            out_pdst,
    output logic [PREG_W-1:0]            out_prs1,
    output logic [PREG_W-1:0]            out_prs2,
    output logic                         out_prs1_busy,
    output logic                         out_prs2_busy,
    output logic [BR_MASK_W-1:0]         out_br_mask,
    output logic                         slot_two_part,
    output logic [PAYLOAD_W-1:0]         slot_payload,
    output logic [PREG_W-1:0]            slot_pdst,
    output logic [PREG_W-1:0]            slot_prs1,
    output logic [PREG_W-1:0]            slot_prs2,
    output logic                         slot_prs1_busy,
    output logic                         slot_prs2_busy,
    output logic [BR_MASK_W-1:0]         slot_br_mask
);

    slot_state_e state_q, state_d;
    slot_uop_t   uop_q, uop_d, uop_next, uop_load;

    logic hit1, hit2, in_hit1, in_hit2;
    logic is_v1, is_v2;
    logic p1_ready, p2_ready;
    logic fire, prune, mispredict, mp_kill, in_mp_kill;

    wakeup_match #(.NUM_WAKEUP(NUM_WAKEUP), .PREG_W(PREG_W)) u_match_prs1 (
        .tag_i(uop_q.prs1), .wakeup_valid_i(wakeup_valid), .wakeup_pdst_i(wakeup_pdst),
        .hit_o(hit1)
    );
    wakeup_match #(.NUM_WAKEUP(NUM_WAKEUP), .PREG_W(PREG_W)) u_match_prs2 (
        .tag_i(uop_q.prs2), .wakeup_valid_i(wakeup_valid), .wakeup_pdst_i(wakeup_pdst),
        .hit_o(hit2)
    );
    // Incoming uop sees the same wakeups so a tag produced this cycle is not lost.
    wakeup_match #(.NUM_WAKEUP(NUM_WAKEUP), .PREG_W(PREG_W)) u_match_in_prs1 (
        .tag_i(in_prs1), .wakeup_valid_i(wakeup_valid), .wakeup_pdst_i(wakeup_pdst),
        .hit_o(in_hit1)
    );
    wakeup_match #(.NUM_WAKEUP(NUM_WAKEUP), .PREG_W(PREG_W)) u_match_in_prs2 (
        .tag_i(in_prs2), .wakeup_valid_i(wakeup_valid), .wakeup_pdst_i(wakeup_pdst),
        .hit_o(in_hit2)
    );

    assign valid      = (state_q != S_INVALID);
    assign is_v1      = (state_q == S_VALID_1);
    assign is_v2      = (state_q == S_VALID_2);
    assign prune      = br_resolve_valid & ~br_mispredict;
    assign mispredict = br_resolve_valid & br_mispredict;
    assign mp_kill    = valid & mispredict & (|(uop_q.br_mask & br_resolve_mask));
    assign in_mp_kill = mispredict & (|(in_br_mask & br_resolve_mask));

`ifdef ISSUE_SLOT_WAKEUP_BYPASS_EN
    assign p1_ready = ~uop_q.prs1_busy | hit1;
    assign p2_ready = ~uop_q.prs2_busy | hit2;
`else
    assign p1_ready = ~uop_q.prs1_busy;
    assign p2_ready = ~uop_q.prs2_busy;
`endif

    // Issue request: first half of a two-part uop only needs prs1.
    always_comb begin
        unique case (state_q)
            S_VALID_1: request = p1_ready & p2_ready;
            S_VALID_2: request = p1_ready;
            default:   request = 1'b0;
        endcase
    end

    // A grant without a request is ignored.
    assign fire          = grant & request;
    assign will_be_valid = valid & ~kill & ~mp_kill & ~(fire & is_v1);

    // Held uop after this cycle's wakeups, pruning and grant.
    always_comb begin
        uop_next           = uop_q;
        uop_next.prs1_busy = uop_q.prs1_busy & ~hit1 & ~(fire & is_v2);
        uop_next.prs2_busy = uop_q.prs2_busy & ~hit2;
        uop_next.br_mask   = prune_mask(uop_q.br_mask, br_resolve_mask, prune);
    end

    // Incoming uop filtered by this cycle's wakeups and pruning.
    always_comb begin
        uop_load.payload   = in_payload;
        uop_load.pdst      = in_pdst;
        uop_load.prs1      = in_prs1;
        uop_load.prs2      = in_prs2;
        uop_load.prs1_busy = in_prs1_busy & ~in_hit1;
        uop_load.prs2_busy = in_prs2_busy & ~in_hit2;
        uop_load.br_mask   = prune_mask(in_br_mask, br_resolve_mask, prune);
    end

    // Next state in priority order: kill, mispredict, clear/load, grant, hold.
    always_comb begin
        state_d = state_q;
        uop_d   = uop_next;
        if (kill || mp_kill) begin
            state_d = S_INVALID;
        end else if (clear || !valid) begin
            if (in_valid && !in_mp_kill) begin
                state_d = in_two_part ? S_VALID_2 : S_VALID_1;
                uop_d   = uop_load;
            end else begin
                state_d = S_INVALID;
            end
        end else if (fire) begin
            state_d = is_v2 ? S_VALID_1 : S_INVALID;
        end
    end

    // Slot state and contents; reset drops the slot immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_INVALID;
            uop_q   <= '0;
        end else begin
            state_q <= state_d;
            uop_q   <= uop_d;
        end
    end

    // Compaction view for the slot below.
    assign out_valid     = will_be_valid;
    assign out_two_part  = will_be_valid & is_v2 & ~fire;
    assign out_payload   = uop_next.payload;
    assign out_pdst      = uop_next.pdst;
    assign out_prs1      = uop_next.prs1;
    assign out_prs2      = uop_next.prs2;
    assign out_prs1_busy = uop_next.prs1_busy;
    assign out_prs2_busy = uop_next.prs2_busy;
    assign out_br_mask   = uop_next.br_mask;

    assign slot_two_part  = is_v2;
    assign slot_payload   = uop_q.payload;
    assign slot_pdst      = uop_q.pdst;
    assign slot_prs1      = uop_q.prs1;
    assign slot_prs2      = uop_q.prs2;
    assign slot_prs1_busy = uop_q.prs1_busy;
    assign slot_prs2_busy = uop_q.prs2_busy;
    assign slot_br_mask   = uop_q.br_mask;

endmodule

// File: tb/tb_issue_slot_gen.sv
// Self-checking bench for issue_slot_gen: directed scenarios plus randomized
// traffic against a behavioural slot model tracking remaining issue count.
module tb_issue_slot_gen;

    localparam int NW = 2;
    localparam int PW = 7;
    localparam int BW = 12;
    localparam int DW = 64;
`ifdef ISSUE_SLOT_WAKEUP_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic in_valid, in_two_part;
    logic [DW-1:0] in_payload;
    logic [PW-1:0] in_pdst, in_prs1, in_prs2;
    logic in_prs1_busy, in_prs2_busy;
    logic [BW-1:0] in_br_mask;
    logic [NW-1:0] wakeup_valid;
    logic [NW*PW-1:0] wakeup_pdst;
    logic br_resolve_valid, br_mispredict, grant, kill, clear;
    logic [BW-1:0] br_resolve_mask;
    logic valid, will_be_valid, request;
    logic out_valid, out_two_part, out_prs1_busy, out_prs2_busy;
    logic [DW-1:0] out_payload;
    logic [PW-1:0] out_pdst, out_prs1, out_prs2;
    logic [BW-1:0] out_br_mask;
    logic slot_two_part, slot_prs1_busy, slot_prs2_busy;
    logic [DW-1:0] slot_payload;
    logic [PW-1:0] slot_pdst, slot_prs1, slot_prs2;
    logic [BW-1:0] slot_br_mask;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: m_left = issues still owed (0 means empty slot).
    int            m_left, n_left;
    logic [DW-1:0] m_payload, n_payload;
    logic [PW-1:0] m_pdst, m_prs1, m_prs2, n_pdst, n_prs1, n_prs2;
    bit            m_b1, m_b2, n_b1, n_b2;
    logic [BW-1:0] m_mask, n_mask;
    bit            e_valid, e_req, e_wbv, e_out_two, e_out_b1, e_out_b2;
    logic [BW-1:0] e_out_mask;

    issue_slot_gen dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_two_part(in_two_part), .in_payload(in_payload),
        .in_pdst(in_pdst), .in_prs1(in_prs1), .in_prs2(in_prs2),
        .in_prs1_busy(in_prs1_busy), .in_prs2_busy(in_prs2_busy), .in_br_mask(in_br_mask),
        .wakeup_valid(wakeup_valid), .wakeup_pdst(wakeup_pdst),
        .br_resolve_valid(br_resolve_valid), .br_resolve_mask(br_resolve_mask),
        .br_mispredict(br_mispredict), .grant(grant), .kill(kill), .clear(clear),
        .valid(valid), .will_be_valid(will_be_valid), .request(request),
        .out_valid(out_valid), .out_two_part(out_two_part), .out_payload(out_payload),
        .out_pdst(out_pdst), .out_prs1(out_prs1), .out_prs2(out_prs2),
        .out_prs1_busy(out_prs1_busy), .out_prs2_busy(out_prs2_busy),
        .out_br_mask(out_br_mask),
        .slot_two_part(slot_two_part), .slot_payload(slot_payload), .slot_pdst(slot_pdst),
        .slot_prs1(slot_prs1), .slot_prs2(slot_prs2), .slot_prs1_busy(slot_prs1_busy),
        .slot_prs2_busy(slot_prs2_busy), .slot_br_mask(slot_br_mask)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit woke(input logic [PW-1:0] tag);
        for (int i = 0; i < NW; i++) begin
            if (wakeup_valid[i] && (wakeup_pdst[i*PW +: PW] == tag)) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic reset_model();
        m_left = 0; m_payload = '0; m_pdst = '0; m_prs1 = '0; m_prs2 = '0;
        m_b1 = 1'b0; m_b2 = 1'b0; m_mask = '0;
    endtask

    // Expected outputs for the current inputs, and the slot contents one cycle on.
    task automatic model_eval();
        bit r1, r2, granted, doomed, in_doomed;
        int left_after;
        r1 = !m_b1 || (BYPASS && woke(m_prs1));
        r2 = !m_b2 || (BYPASS && woke(m_prs2));
        e_valid = (m_left != 0);
        e_req   = (m_left == 2) ? r1 : ((m_left == 1) ? (r1 && r2) : 1'b0);
        granted = grant && e_req;
        doomed  = e_valid && br_resolve_valid && br_mispredict
                  && ((m_mask & br_resolve_mask) != '0);
        left_after = (kill || doomed) ? 0 : m_left - int'(granted);
        e_wbv      = (left_after != 0);
        e_out_two  = (left_after == 2);
        e_out_b1   = (granted && m_left == 2) ? 1'b0 : (m_b1 && !woke(m_prs1));
        e_out_b2   = m_b2 && !woke(m_prs2);
        e_out_mask = (br_resolve_valid && !br_mispredict) ? (m_mask & ~br_resolve_mask) : m_mask;
        n_payload = m_payload; n_pdst = m_pdst; n_prs1 = m_prs1; n_prs2 = m_prs2;
        n_b1 = e_out_b1; n_b2 = e_out_b2; n_mask = e_out_mask;
        if (kill || doomed) begin
            n_left = 0;
        end else if (clear || m_left == 0) begin
            in_doomed = br_resolve_valid && br_mispredict && ((in_br_mask & br_resolve_mask) != '0);
            if (in_valid && !in_doomed) begin
                n_left = in_two_part ? 2 : 1;
                n_payload = in_payload; n_pdst = in_pdst; n_prs1 = in_prs1; n_prs2 = in_prs2;
                n_b1 = in_prs1_busy && !woke(in_prs1);
                n_b2 = in_prs2_busy && !woke(in_prs2);
                n_mask = (br_resolve_valid && !br_mispredict) ? (in_br_mask & ~br_resolve_mask)
                                                              : in_br_mask;
            end else begin
                n_left = 0;
            end
        end else begin
            n_left = left_after;
        end
    endtask

    task automatic check_all();
        model_eval();
        check_eq("valid", 64'(valid), 64'(e_valid));
        check_eq("request", 64'(request), 64'(e_req));
        check_eq("will_be_valid", 64'(will_be_valid), 64'(e_wbv));
        check_eq("out_valid", 64'(out_valid), 64'(e_wbv));
        if (grant) check_eq("grant_protocol", 64'(request), 64'd1);
        if (e_wbv) begin
            check_eq("out_two_part", 64'(out_two_part), 64'(e_out_two));
            check_eq("out_payload", out_payload, m_payload);
            check_eq("out_pdst", 64'(out_pdst), 64'(m_pdst));
            check_eq("out_prs1", 64'(out_prs1), 64'(m_prs1));
            check_eq("out_prs2", 64'(out_prs2), 64'(m_prs2));
            check_eq("out_prs1_busy", 64'(out_prs1_busy), 64'(e_out_b1));
            check_eq("out_prs2_busy", 64'(out_prs2_busy), 64'(e_out_b2));
            check_eq("out_br_mask", 64'(out_br_mask), 64'(e_out_mask));
        end
        if (e_valid) begin
            check_eq("slot_two_part", 64'(slot_two_part), 64'(m_left == 2));
            check_eq("slot_payload", slot_payload, m_payload);
            check_eq("slot_pdst", 64'(slot_pdst), 64'(m_pdst));
            check_eq("slot_prs1_busy", 64'(slot_prs1_busy), 64'(m_b1));
            check_eq("slot_prs2_busy", 64'(slot_prs2_busy), 64'(m_b2));
            check_eq("slot_br_mask", 64'(slot_br_mask), 64'(m_mask));
        end
    endtask

    // Called just after a falling edge with inputs driven; returns at the next one.
    task automatic tick();
        #1;
        check_all();
        @(posedge clk);
        #1;
        m_left = n_left; m_payload = n_payload; m_pdst = n_pdst; m_prs1 = n_prs1;
        m_prs2 = n_prs2; m_b1 = n_b1; m_b2 = n_b2; m_mask = n_mask;
        @(negedge clk);
    endtask

    task automatic idle();
        in_valid = 0; in_two_part = 0; in_payload = '0; in_pdst = '0; in_prs1 = '0;
        in_prs2 = '0; in_prs1_busy = 0; in_prs2_busy = 0; in_br_mask = '0;
        wakeup_valid = '0; wakeup_pdst = '0; br_resolve_valid = 0; br_resolve_mask = '0;
        br_mispredict = 0; grant = 0; kill = 0; clear = 0;
    endtask

    task automatic load_uop(input bit two, input logic [DW-1:0] pl, input logic [PW-1:0] pd,
                            input logic [PW-1:0] s1, input bit b1, input logic [PW-1:0] s2,
                            input bit b2, input logic [BW-1:0] mask);
        in_valid = 1; in_two_part = two; in_payload = pl; in_pdst = pd;
        in_prs1 = s1; in_prs1_busy = b1; in_prs2 = s2; in_prs2_busy = b2; in_br_mask = mask;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        reset_model();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check_eq("rst_valid", 64'(valid), 64'd0);
        check_eq("rst_request", 64'(request), 64'd0);
        check_eq("rst_wbv", 64'(will_be_valid), 64'd0);
        check_eq("rst_slot_payload", slot_payload, 64'd0);
        check_eq("rst_slot_pdst", 64'(slot_pdst), 64'd0);
        check_eq("rst_slot_br_mask", 64'(slot_br_mask), 64'd0);
        @(negedge clk);

        // Load and wakeup on port 1.
        load_uop(0, 64'hA5A5_0001, 7'd20, 7'd5, 1, 7'd9, 0, '0);
        tick(); idle(); #1;
        check_eq("ld_valid", 64'(valid), 64'd1);
        check_eq("ld_request", 64'(request), 64'd0);
        wakeup_valid = 2'b10; wakeup_pdst = {7'd5, 7'd0}; #1;
        check_eq("wake_req_same", 64'(request), 64'(BYPASS));
        tick(); idle(); #1;
        check_eq("wake_req_next", 64'(request), 64'd1);
        grant = 1; tick(); idle(); #1;
        check_eq("grant_empties", 64'(valid), 64'd0);

        // Two-part store.
        load_uop(1, 64'hBEEF, 7'd21, 7'd4, 0, 7'd3, 1, '0);
        tick(); idle(); #1;
        check_eq("tp_request", 64'(request), 64'd1);
        check_eq("tp_two_part", 64'(slot_two_part), 64'd1);
        grant = 1; tick(); idle(); #1;
        check_eq("tp_valid_after_g1", 64'(valid), 64'd1);
        check_eq("tp_req_after_g1", 64'(request), 64'd0);
        check_eq("tp_state_v1", 64'(slot_two_part), 64'd0);
        wakeup_valid = 2'b01; wakeup_pdst = {7'd0, 7'd3};
        tick(); idle(); #1;
        check_eq("tp_req_p2", 64'(request), 64'd1);
        grant = 1; tick(); idle(); #1;
        check_eq("tp_done", 64'(valid), 64'd0);

        // Branch prune then mispredict.
        load_uop(0, 64'h77, 7'd22, 7'd1, 0, 7'd2, 0, 12'h004);
        tick(); idle();
        br_resolve_valid = 1; br_resolve_mask = 12'h004;
        tick(); idle(); #1;
        check_eq("br_pruned", 64'(slot_br_mask), 64'd0);
        check_eq("br_still_valid", 64'(valid), 64'd1);
        clear = 1; load_uop(0, 64'h78, 7'd23, 7'd1, 0, 7'd2, 0, 12'h004);
        tick(); idle();
        br_resolve_valid = 1; br_resolve_mask = 12'h004; br_mispredict = 1; #1;
        check_eq("mp_wbv", 64'(will_be_valid), 64'd0);
        tick(); idle(); #1;
        check_eq("mp_valid", 64'(valid), 64'd0);

        // Clear with simultaneous load.
        load_uop(0, 64'hAAAA, 7'd30, 7'd5, 1, 7'd6, 1, '0);
        tick(); idle();
        clear = 1; load_uop(0, 64'hBBBB, 7'd40, 7'd1, 0, 7'd2, 0, '0);
        wakeup_valid = 2'b01; wakeup_pdst = {7'd0, 7'd5}; #1;
        check_eq("clr_out_pdst", 64'(out_pdst), 64'd30);
        check_eq("clr_out_b1", 64'(out_prs1_busy), 64'd0);
        check_eq("clr_out_b2", 64'(out_prs2_busy), 64'd1);
        tick(); idle(); #1;
        check_eq("clr_slot_pdst", 64'(slot_pdst), 64'd40);

        // Kill beats grant and load.
        kill = 1; grant = 1; load_uop(0, 64'hCCCC, 7'd50, 7'd1, 0, 7'd2, 0, '0);
        tick(); idle(); #1;
        check_eq("kill_valid", 64'(valid), 64'd0);

        // Asynchronous reset in the middle of a cycle.
        load_uop(1, 64'hDDDD, 7'd60, 7'd1, 0, 7'd2, 0, '0);
        tick(); idle(); #1;
        check_eq("pre_rst_valid", 64'(valid), 64'd1);
        #2 reset = 1'b1;
        #1;
        check_eq("async_rst_valid", 64'(valid), 64'd0);
        check_eq("async_rst_request", 64'(request), 64'd0);
        check_eq("async_rst_pdst", 64'(slot_pdst), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        reset_model();

        // Randomized traffic.
        for (int c = 0; c < 500; c++) begin
            idle();
            in_valid     = ($urandom_range(0, 1) == 1);
            in_two_part  = ($urandom_range(0, 2) == 0);
            in_payload   = {$urandom, $urandom};
            in_pdst      = 7'($urandom_range(0, 127));
            in_prs1      = 7'($urandom_range(0, 7));
            in_prs2      = 7'($urandom_range(0, 7));
            in_prs1_busy = ($urandom_range(0, 1) == 1);
            in_prs2_busy = ($urandom_range(0, 1) == 1);
            in_br_mask   = ($urandom_range(0, 3) == 0) ? 12'h0 : 12'(1 << $urandom_range(0, 3));
            wakeup_valid = 2'($urandom_range(0, 3));
            wakeup_pdst  = {7'($urandom_range(0, 7)), 7'($urandom_range(0, 7))};
            br_resolve_valid = ($urandom_range(0, 3) == 0);
            br_resolve_mask  = 12'(1 << $urandom_range(0, 3));
            br_mispredict    = ($urandom_range(0, 3) == 0);
            kill  = ($urandom_range(0, 31) == 0);
            clear = ($urandom_range(0, 4) == 0);
            model_eval();
            grant = e_req && ($urandom_range(0, 1) == 1);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/issue_slot_gen.md
# issue_slot_gen

Parametrised issue-queue slot. Holds one micro-op, tracks operand readiness from N wakeup ports, and prunes or kills the op on branch resolution. It arbitrates for issue via request/grant and supports two-part issue, where a store issues address and data separately. It sits in the collapsing issue queue: each slot feeds its next-state uop to the slot below, and successive slots are chained through `out_*`/`in_*`.

## Interface
- `NUM_WAKEUP`, 2: number of wakeup ports.
- `PREG_W`, 7: physical register tag width.
- `BR_MASK_W`, 12: branch mask width.
- `PAYLOAD_W`, 64: opaque uop payload (uopc, inst, rtypes, flags), carried untouched.
- Clock and reset: one clock; reset is asynchronous and active-high (`clk`, `reset`).
- `clk` in 1: clock.
- `reset` in 1: async active-high reset.
- `in_valid` in 1: load uop this cycle.
- `in_two_part` in 1: uop issues twice (s_valid_2).
- `in_payload` in PAYLOAD_W: opaque uop bits.
- `in_pdst`, `in_prs1`, `in_prs2` in PREG_W each: destination and source tags.
- `in_prs1_busy`, `in_prs2_busy` in 1: source not yet ready.
- `in_br_mask` in BR_MASK_W: branches this uop depends on.
- `wakeup_valid` in NUM_WAKEUP: per-port wakeup strobe.
- `wakeup_pdst` in NUM_WAKEUP*PREG_W: per-port tag, port i at [i*PREG_W +: PREG_W].
- `br_resolve_valid` in 1: a branch resolved.
- `br_resolve_mask` in BR_MASK_W: one-hot resolved branch.
- `br_mispredict` in 1: resolved branch mispredicted.
- `grant` in 1: issue selected this slot.
- `kill` in 1: pipeline flush.
- `clear` in 1: slot contents shift out to the next slot this cycle.
- `valid` out 1: state != s_invalid.
- `will_be_valid` out 1: slot still holds a live uop next cycle, excluding load and clear.
- `request` out 1: ready to issue.
- `out_*` out, same widths as `in_*`: next-state uop for compaction, with this cycle's wakeups, branch pruning, and grant applied.
- `slot_*` out, same widths: current registered uop, fed to issue/regread.

## Operation
- States: S_INVALID=0, S_VALID_1=1, S_VALID_2=2.
- The slot accepts a load from `in_valid` when it is S_INVALID or when `clear` is asserted. Next state is S_VALID_2 if `in_two_part`, else S_VALID_1.
- `request`:
  - S_VALID_1: asserted when both p1_busy and p2_busy are clear.
  - S_VALID_2: asserted when p1_busy is clear.
  - S_INVALID: 0.
- `grant` in S_VALID_1 moves the slot to S_INVALID.
- `grant` in S_VALID_2 moves the slot to S_VALID_1 and forces p1_busy to 0. The second issue then waits only on p2.
- Wakeup:
  - Any port i with `wakeup_valid[i]` and `wakeup_pdst[i]==prs1` clears p1_busy. The same applies to prs2.
  - Multiple ports matching the same tag are legal and have the same effect as one match.
- Branch resolve:
  - With `br_resolve_valid` and `br_mispredict`, a slot whose br_mask overlaps `br_resolve_mask` goes to S_INVALID.
  - With `br_resolve_valid` and no mispredict, the slot clears the matching bit from br_mask.
- Priority per cycle, highest first:
  1. reset
  2. `kill`
  3. mispredict kill
  4. `clear` (load if `in_valid`, else S_INVALID)
  5. `grant`
  6. wakeup / branch prune
- Wakeups and pruning also apply to a uop being loaded in the same cycle. Its `in_*_busy` and `in_br_mask` are filtered before capture.
- `will_be_valid` = valid & !kill & !mispredict-kill & !(grant & S_VALID_1).
- `grant` while `request`=0 is a protocol error. The slot ignores it; the bench asserts it never happens.

## Timing
- Reset: state=S_INVALID, `valid`=`request`=`will_be_valid`=0, and all `slot_*` fields are 0.
- Load at cycle t: `valid`=1 at t+1. `request` is at t+1 at the earliest.
- Wakeup at cycle t clears busy at t+1, so `request` rises at t+1. The exception is when ISSUE_SLOT_WAKEUP_BYPASS_EN is defined (see Configuration).
- Grant at cycle t: state update at t+1.
- `out_*` and `will_be_valid` are combinational from the current state plus this cycle's inputs.
- Reset asserted mid-operation drops the slot immediately and asynchronously to the reset state.

## Configuration
- `ISSUE_SLOT_WAKEUP_BYPASS_EN` defined:
  - `request` also includes this cycle's matching wakeups, so a wakeup at t can be granted at t.
  - Grant of a two-part uop at t with a p2 wakeup at t leaves S_VALID_1 with p2 ready.
- Undefined: `request` is purely registered, with one bubble after wakeup.

## Structure
- `issue_pkg`:
  - `slot_state_e` enum (S_INVALID/S_VALID_1/S_VALID_2).
  - Default widths: PREG_W, BR_MASK_W.
  - `slot_uop_t` packed struct for the stored fields.
- Sub-module `wakeup_match`: compares one tag against NUM_WAKEUP ports and returns a hit.
  - Instantiated twice, for prs1 and prs2.
  - Reused on the load path.

## Test plan
- **Load and wakeup:** load prs1=5 busy, prs2=9 ready. Wakeup port1 pdst=5 at t. Expect `request`=1 at t+1 (t with BYPASS_EN). Grant, then `valid`=0 next cycle.
- **Two-part store:**
  - Load with `in_two_part`, p1 ready, p2 busy. Expect `request`=1 in S_VALID_2.
  - Grant. Expect S_VALID_1 with `request`=0.
  - Wakeup p2. Expect `request`=1.
- **Branch:**
  - br_mask=0x004, resolve mask=0x004 with no mispredict. Expect br_mask=0 and slot still valid.
  - Repeat with mispredict. Expect `valid`=0 and `will_be_valid`=0 the same cycle.
- **Clear with load:** `clear`=1 and `in_valid`=1 with a new uop in the same cycle. Expect `out_*` to carry the old uop with wakeups applied, and `slot_*` to hold the new uop next cycle.
- **Kill priority:** `kill`, `grant` and `in_valid` asserted together. Expect S_INVALID.
- **Reset mid-operation:** async reset mid-cycle while S_VALID_2. Expect `valid`/`request` to drop before the next edge.
